// File: rtl/fifo_wr_front_if.sv
// rtl/fifo_wr_front_if.sv - producer, pointer-block, RAM and CDC signals of the FIFO write front end
interface fifo_wr_front_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [N-1:0]  wr_ptr;
    logic          o_fifo_full;
    logic [N-1:0]  rd_ptr_gray;
    logic          wr_en;
    logic [N-2:0]  wr_addr;
    logic [DW-1:0] wr_data;
    logic [N-1:0]  rd_ptr_sync;
    logic [N-1:0]  wr_ptr_gray;
    logic [N-1:0]  fill_level;
    logic          almost_full;

    modport slave (
        input  s_valid, s_data, wr_ptr, o_fifo_full, rd_ptr_gray,
        output s_ready, wr_en, wr_addr, wr_data, rd_ptr_sync, wr_ptr_gray, fill_level, almost_full
    );

    modport master (
        output s_valid, s_data, wr_ptr, o_fifo_full, rd_ptr_gray,
        input  s_ready, wr_en, wr_addr, wr_data, rd_ptr_sync, wr_ptr_gray, fill_level, almost_full
    );
endinterface

// File: rtl/fifo_wr_front.sv
// rtl/fifo_wr_front.sv - async FIFO write-domain front end: skid handshake, read-pointer sync, Gray out, level
module fifo_wr_front #(
    parameter int N           = 4,
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6
) (
    input  logic           wr_clk,
    input  logic           wr_rst,
    fifo_wr_front_if.slave bus
);
    localparam logic [N-1:0] AF_LVL = N'(AF_THRESH);

    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          s_ready_q;
    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  rd_bin;
    logic [N-1:0]  rd_ptr_sync_q;
    logic [N-1:0]  wr_ptr_gray_q;
    logic          accept;
    logic          avail;
    logic          wr_en;
    logic [N-1:0]  fill;

    assign accept = bus.s_valid && s_ready_q;
    assign avail  = skid_valid_q || accept;
    assign wr_en  = avail && !bus.o_fifo_full;

    // A held skid word drains first; s_ready is low while it is held, so no input competes with it.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            if (!bus.o_fifo_full) begin
                skid_valid_d = 1'b0;
            end
        end else if (accept && bus.o_fifo_full) begin
            skid_valid_d = 1'b1;
            skid_data_d  = bus.s_data;
        end
    end

    always_comb begin
        rd_bin = '0;
        for (int i = 0; i < N; i++) begin
            rd_bin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
            s_ready_q     <= 1'b0;
            rd_ptr_sync_q <= '0;
            wr_ptr_gray_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            s_ready_q     <= !skid_valid_d;
            sync_q[0]     <= bus.rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rd_ptr_sync_q <= rd_bin;
            wr_ptr_gray_q <= bus.wr_ptr ^ (bus.wr_ptr >> 1);
        end
    end

    // The synchronised read pointer lags, so this level can only over-report.
    assign fill = bus.wr_ptr - rd_ptr_sync_q;

    assign bus.s_ready     = s_ready_q;
    assign bus.wr_en       = wr_en;
    assign bus.wr_addr     = bus.wr_ptr[N-2:0];
    assign bus.wr_data     = skid_valid_q ? skid_data_q : bus.s_data;
    assign bus.rd_ptr_sync = rd_ptr_sync_q;
    assign bus.wr_ptr_gray = wr_ptr_gray_q;
    assign bus.fill_level  = fill;
    assign bus.almost_full = (fill >= AF_LVL);
endmodule

// File: tb/tb_fifo_wr_front.sv
// tb/tb_fifo_wr_front.sv - directed self-checking bench for fifo_wr_front with a pointer-block model
module tb_fifo_wr_front;
    logic wr_clk;
    logic wr_rst;
    int   n_checks;
    int   n_fail;
    bit   ptr_model;
    bit   acc_last;
    logic [7:0] data;

    fifo_wr_front_if #(.N(4), .DW(8)) bus ();

    fifo_wr_front #(.N(4), .DW(8), .SYNC_STAGES(2), .AF_THRESH(6)) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus)
    );

    initial begin
        wr_clk = 1'b0;
        forever #10 wr_clk = ~wr_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic upd_full();
        bus.o_fifo_full = (bus.wr_ptr == {~bus.rd_ptr_sync[3], bus.rd_ptr_sync[2:0]});
    endtask

    task automatic step();
        logic en;
        logic acc;
        @(negedge wr_clk);
        en  = bus.wr_en;
        acc = bus.s_valid && bus.s_ready;
        @(posedge wr_clk);
        #1;
        if (ptr_model && en) bus.wr_ptr = bus.wr_ptr + 4'd1;
        acc_last = acc;
        upd_full();
    endtask

    logic [3:0] t4_ptr  [4] = '{4'd7, 4'd8, 4'd15, 4'd0};
    logic [3:0] t4_gray [4] = '{4'b0100, 4'b1100, 4'b1000, 4'b0000};
    logic [2:0] t4_addr [4] = '{3'd7, 3'd0, 3'd7, 3'd0};
    logic       t5_af   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] t6_vpat;

    initial begin
        n_checks = 0;
        n_fail = 0;
        ptr_model = 1'b0;
        acc_last = 1'b0;
        wr_rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.wr_ptr = '0;
        bus.rd_ptr_gray = '0;
        bus.o_fifo_full = 1'b0;
        step();
        step();
        #1;
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_rd_sync", bus.rd_ptr_sync, 0);
        chk("rst_wr_gray", bus.wr_ptr_gray, 0);
        chk("rst_fill", bus.fill_level, 0);
        chk("rst_af", bus.almost_full, 0);
        step();
        wr_rst = 1'b0;
        #1;
        chk("rel_s_ready_pre", bus.s_ready, 0);
        step();
        #1;
        chk("rel_s_ready_post", bus.s_ready, 1);

        // fill to full; the ninth word lands in the skid
        ptr_model = 1'b1;
        data = 8'h10;
        bus.s_valid = 1'b1;
        bus.s_data = data;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t2_wr_en", bus.wr_en, 1);
            chk("t2_wr_addr", bus.wr_addr, i);
            chk("t2_wr_data", bus.wr_data, 8'h10 + i);
            step();
            if (acc_last) data = data + 8'd1;
            bus.s_data = data;
        end
        #1;
        chk("t2_fill_full", bus.fill_level, 8);
        chk("t2_af_full", bus.almost_full, 1);
        chk("t2_wr_en_full", bus.wr_en, 0);
        chk("t2_s_ready_full", bus.s_ready, 1);
        step();
        if (acc_last) data = data + 8'd1;
        bus.s_data = data;
        #1;
        chk("t2_skid_s_ready", bus.s_ready, 0);
        chk("t2_skid_wr_en", bus.wr_en, 0);
        chk("t2_skid_wr_data", bus.wr_data, 8'h18);

        bus.rd_ptr_gray = 4'b0010;
        step();
        step();
        #1;
        chk("t3_sync_2edges", bus.rd_ptr_sync, 0);
        chk("t3_wr_en_2edges", bus.wr_en, 0);
        step();
        #1;
        chk("t3_sync_3edges", bus.rd_ptr_sync, 3);
        chk("t3_drain_wr_en", bus.wr_en, 1);
        chk("t3_drain_data", bus.wr_data, 8'h18);
        chk("t3_drain_addr", bus.wr_addr, 0);
        chk("t3_fill", bus.fill_level, 5);
        chk("t3_af", bus.almost_full, 0);
        chk("t3_s_ready_drain", bus.s_ready, 0);
        step();
        #1;
        chk("t3_s_ready_after", bus.s_ready, 1);
        chk("t3_next_wr_en", bus.wr_en, 1);
        chk("t3_next_data", bus.wr_data, 8'h19);
        chk("t3_next_addr", bus.wr_addr, 1);
        bus.s_valid = 1'b0;

        ptr_model = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_ptr = t4_ptr[i];
            upd_full();
            #1;
            chk("t4_wr_addr", bus.wr_addr, t4_addr[i]);
            chk("t4_wr_en", bus.wr_en, 0);
            step();
            #1;
            chk("t4_wr_gray", bus.wr_ptr_gray, t4_gray[i]);
        end

        bus.rd_ptr_gray = 4'b0000;
        bus.wr_ptr = 4'd0;
        upd_full();
        step();
        step();
        step();
        #1;
        chk("t5_sync0", bus.rd_ptr_sync, 0);
        chk("t5_fill0", bus.fill_level, 0);
        chk("t5_af0", bus.almost_full, 0);
        ptr_model = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 8'h30;
        for (int k = 0; k < 6; k++) begin
            step();
            #1;
            chk("t5_fill", bus.fill_level, k + 1);
            chk("t5_af", bus.almost_full, t5_af[k]);
        end
        bus.s_valid = 1'b0;

        ptr_model = 1'b0;
        t6_vpat = 8'b0110_1011;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = t6_vpat[i];
            bus.s_data = 8'h40 + 8'(i);
            #1;
            chk("t6_wr_en", bus.wr_en, t6_vpat[i]);
            if (t6_vpat[i]) chk("t6_wr_data", bus.wr_data, 8'h40 + i);
            step();
        end
        bus.s_valid = 1'b0;

        // reset while a word sits in the skid
        bus.wr_ptr = 4'd10;
        bus.rd_ptr_gray = 4'b0011;
        upd_full();
        step();
        step();
        step();
        #1;
        chk("t1_sync", bus.rd_ptr_sync, 2);
        chk("t1_fill", bus.fill_level, 8);
        bus.s_valid = 1'b1;
        bus.s_data = 8'h55;
        step();
        bus.s_valid = 1'b0;
        #1;
        chk("t1_skid_s_ready", bus.s_ready, 0);
        chk("t1_skid_wr_en", bus.wr_en, 0);
        chk("t1_skid_data", bus.wr_data, 8'h55);
        chk("t1_wr_gray", bus.wr_ptr_gray, 4'b1111);
        bus.rd_ptr_gray = 4'b0000;
        #1;
        wr_rst = 1'b1;
        #1;
        chk("t1_rst_s_ready", bus.s_ready, 0);
        chk("t1_rst_rd_sync", bus.rd_ptr_sync, 0);
        chk("t1_rst_wr_gray", bus.wr_ptr_gray, 0);
        chk("t1_rst_fill", bus.fill_level, 10);
        upd_full();
        #1;
        chk("t1_rst_wr_en", bus.wr_en, 0);
        step();
        wr_rst = 1'b0;
        #1;
        chk("t1_rel_s_ready_pre", bus.s_ready, 0);
        step();
        #1;
        chk("t1_rel_s_ready", bus.s_ready, 1);
        chk("t1_rel_wr_en", bus.wr_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
